// File: rtl/commit_pkg.sv
// ----------------------------------------------------------------------------
// commit_pkg
//
// Shared types and default constants for the commit monitor slice.
//   commit_entry_t : one retired instruction as the consumer sees it
//                    (pc, ebreak flag, mmio flag)
//   cm_state_e     : monitor lifecycle RUN -> DRAIN -> HALT, or RUN -> HANG
//   CM_*           : default parameter values for commit_monitor/commit_fifo
// ----------------------------------------------------------------------------
package commit_pkg;

    localparam int CM_NR_COMMIT   = 2;
    localparam int CM_PC_W        = 32;
    localparam int CM_DEPTH       = 8;
    localparam int CM_WDOG_CYCLES = 4096;

    typedef struct packed {
        logic [CM_PC_W-1:0] pc;
        logic               ebreak;
        logic               mmio;
    } commit_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2,
        HANG  = 2'd3
    } cm_state_e;

endpackage

// File: rtl/commit_fifo.sv
// ----------------------------------------------------------------------------
// commit_fifo
//
// Circular buffer that accepts up to NR_COMMIT entries per cycle (written in
// order starting at the write pointer) and releases one entry per cycle from
// the head. Pointers carry an extra wrap bit so full and empty fall out of a
// plain pointer comparison/difference.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (empties the buffer)
//   wr_num_i   in   number of entries to write this cycle (0..NR_COMMIT)
//   wr_data_i  in   NR_COMMIT packed entries, slot i at [i*ENTRY_W +: ENTRY_W]
//   rd_en_i    in   pop the head entry (caller guarantees non-empty)
//   rd_data_o  out  head entry, straight from the storage array
//   count_o    out  occupied entries
//   empty_o    out  buffer holds no entries
// ----------------------------------------------------------------------------
module commit_fifo
    import commit_pkg::*;
#(
    parameter  int NR_COMMIT = CM_NR_COMMIT,
    parameter  int DEPTH     = CM_DEPTH,
    parameter  int ENTRY_W   = CM_PC_W + 2,
    localparam int AW        = $clog2(DEPTH),
    localparam int PTR_W     = AW + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PTR_W-1:0]             wr_num_i,
    input  logic [NR_COMMIT*ENTRY_W-1:0] wr_data_i,
    input  logic                         rd_en_i,
    output logic [ENTRY_W-1:0]           rd_data_o,
    output logic [PTR_W-1:0]             count_o,
    output logic                         empty_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;

    // Storage and pointers. The array is cleared on reset so the head output
    // reads zero out of reset; the low address bits wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_COMMIT; i++) begin
                if (PTR_W'(i) < wr_num_i) begin
                    mem_q[wr_ptr_q[AW-1:0] + AW'(i)] <= wr_data_i[i*ENTRY_W +: ENTRY_W];
                end
            end
            wr_ptr_q <= wr_ptr_q + wr_num_i;
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/commit_monitor.sv
// ----------------------------------------------------------------------------
// commit_monitor
//
// Multi-channel commit tracker. Retiring instructions from up to NR_COMMIT
// writeback channels are trimmed at the first ebreak, buffered in program
// order and handed one per handshake to the difftest consumer. Tracks retired
// instruction and active cycle counts and flags end-of-program.
//
// Optional feature (macro COMMIT_WDOG_EN): an idle watchdog that moves the
// monitor to HANG after WDOG_CYCLES cycles in RUN without an accepted group.
// Without the macro there is no idle counter and hang is tied low.
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   cmt_valid    per-channel retire strobe, contiguous from channel 0
//   cmt_pc       per-channel PC, channel i at [i*PC_W +: PC_W]
//   cmt_ebreak   per-channel ebreak flag
//   cmt_mmio     per-channel MMIO flag
//   cmt_stall    core must hold its commit group this cycle
//   out_valid    head entry available
//   out_ready    consumer accepts the head
//   out_pc / out_ebreak / out_mmio   head entry fields
//   instret      accepted instruction count (64-bit, wraps)
//   cycles       cycles spent in RUN or DRAIN (64-bit, wraps)
//   finished     ebreak retired and drained (sticky)
//   hang         watchdog expired (sticky)
// ----------------------------------------------------------------------------
module commit_monitor
    import commit_pkg::*;
#(
    parameter int NR_COMMIT   = CM_NR_COMMIT,
    parameter int PC_W        = CM_PC_W,
    parameter int DEPTH       = CM_DEPTH,
    parameter int WDOG_CYCLES = CM_WDOG_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NR_COMMIT-1:0]      cmt_valid,
    input  logic [NR_COMMIT*PC_W-1:0] cmt_pc,
    input  logic [NR_COMMIT-1:0]      cmt_ebreak,
    input  logic [NR_COMMIT-1:0]      cmt_mmio,
    output logic                      cmt_stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_W-1:0]           out_pc,
    output logic                      out_ebreak,
    output logic                      out_mmio,
    output logic [63:0]               instret,
    output logic [63:0]               cycles,
    output logic                      finished,
    output logic                      hang
);

    localparam int PTR_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = PC_W + 2;

    cm_state_e                    state_q;
    logic [63:0]                  instret_q;
    logic [63:0]                  cycles_q;
    logic                         finished_q;

    logic [PTR_W-1:0]             count;
    logic                         fifo_empty;
    logic [ENTRY_W-1:0]           head;
    logic [NR_COMMIT*ENTRY_W-1:0] wr_data;
    logic [PTR_W-1:0]             wr_num;
    logic [PTR_W-1:0]             n_keep;
    logic                         has_ebreak;
    logic                         stop;
    logic                         accept;
    logic                         grp_acc;
    logic                         pop;

    // Group trimming: walk the channels oldest first and keep them until the
    // first invalid channel or up to and including the first ebreak. Anything
    // after an ebreak belongs to a program that has already ended.
    always_comb begin
        n_keep     = '0;
        has_ebreak = 1'b0;
        stop       = 1'b0;
        wr_data    = '0;
        for (int i = 0; i < NR_COMMIT; i++) begin
            wr_data[i*ENTRY_W +: ENTRY_W] = {cmt_pc[i*PC_W +: PC_W], cmt_ebreak[i], cmt_mmio[i]};
            if (!cmt_valid[i]) begin
                stop = 1'b1;
            end else if (!stop) begin
                n_keep = n_keep + PTR_W'(1);
                if (cmt_ebreak[i]) begin
                    has_ebreak = 1'b1;
                    stop       = 1'b1;
                end
            end
        end
    end

    // Stall uses only the registered occupancy; a pop this cycle is not
    // credited, which keeps the check off the consumer's ready path.
    assign cmt_stall = (DEPTH - int'(count)) < NR_COMMIT;
    assign accept    = (state_q == RUN) && !cmt_stall;
    assign grp_acc   = accept && (n_keep != '0);
    assign wr_num    = accept ? n_keep : '0;
    assign pop       = !fifo_empty && out_ready;

    commit_fifo #(
        .NR_COMMIT (NR_COMMIT),
        .DEPTH     (DEPTH),
        .ENTRY_W   (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_num_i  (wr_num),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (count),
        .empty_o   (fifo_empty)
    );

    assign out_valid                     = !fifo_empty;
    assign {out_pc, out_ebreak, out_mmio} = head;

`ifdef COMMIT_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic [31:0] idle_q;
    logic        hang_q;
`endif

    // Lifecycle FSM plus counters. DRAIN waits for the ebreak entry itself to
    // leave the queue before declaring the program finished; HALT and HANG
    // only leave through reset, while the queue keeps draining underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            instret_q  <= '0;
            cycles_q   <= '0;
            finished_q <= 1'b0;
`ifdef COMMIT_WDOG_EN
            idle_q     <= '0;
            hang_q     <= 1'b0;
`endif
        end else begin
            instret_q <= instret_q + 64'(wr_num);
            if (state_q == RUN || state_q == DRAIN) begin
                cycles_q <= cycles_q + 64'd1;
            end
            case (state_q)
                RUN: begin
                    if (accept && has_ebreak) begin
                        state_q <= DRAIN;
                    end
`ifdef COMMIT_WDOG_EN
                    else if (!grp_acc && idle_q == WDOG_LAST) begin
                        state_q <= HANG;
                        hang_q  <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (pop && out_ebreak) begin
                        state_q    <= HALT;
                        finished_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
`ifdef COMMIT_WDOG_EN
            if (state_q == RUN) begin
                idle_q <= grp_acc ? '0 : idle_q + 32'd1;
            end
`endif
        end
    end

    assign instret  = instret_q;
    assign cycles   = cycles_q;
    assign finished = finished_q;
`ifdef COMMIT_WDOG_EN
    assign hang     = hang_q;
`else
    assign hang     = 1'b0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// ----------------------------------------------------------------------------
// tb_commit_monitor
//
// Self-checking bench for commit_monitor (NR_COMMIT=2, DEPTH=8,
// WDOG_CYCLES=16). Expected entries are pushed to a scoreboard queue when a
// group is driven that should be accepted and are compared as the consumer
// handshake pops them. Honours COMMIT_WDOG_EN for the hang expectations.
// ----------------------------------------------------------------------------
module tb_commit_monitor;
    import commit_pkg::*;

    localparam int NR   = 2;
    localparam int PCW  = 32;
    localparam int DEP  = 8;
    localparam int WDOG = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   cmt_valid = '0;
    logic [NR*PCW-1:0] cmt_pc = '0;
    logic [NR-1:0]   cmt_ebreak = '0;
    logic [NR-1:0]   cmt_mmio = '0;
    logic            cmt_stall;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [PCW-1:0]  out_pc;
    logic            out_ebreak;
    logic            out_mmio;
    logic [63:0]     instret;
    logic [63:0]     cycles;
    logic            finished;
    logic            hang;

    int checks = 0;
    int failures = 0;
    commit_entry_t sbQ[$];
    commit_entry_t monExp;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  eb;
        logic [1:0]  mm;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  expMask;
        logic        expStall;
        logic [63:0] expInstret;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    commit_monitor #(
        .NR_COMMIT   (NR),
        .PC_W        (PCW),
        .DEPTH       (DEP),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmt_valid  (cmt_valid),
        .cmt_pc     (cmt_pc),
        .cmt_ebreak (cmt_ebreak),
        .cmt_mmio   (cmt_mmio),
        .cmt_stall  (cmt_stall),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_ebreak (out_ebreak),
        .out_mmio   (out_mmio),
        .instret    (instret),
        .cycles     (cycles),
        .finished   (finished),
        .hang       (hang)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [1:0] eb, input logic [1:0] mm, input logic rdy);
        cmt_valid  = v;
        cmt_pc     = {p1, p0};
        cmt_ebreak = eb;
        cmt_mmio   = mm;
        out_ready  = rdy;
    endtask

    // Push the entries the bench expects to be enqueued for a group.
    task automatic expectEnq(input logic [1:0] mask, input logic [31:0] p0, input logic [31:0] p1,
                             input logic [1:0] eb, input logic [1:0] mm);
        if (mask[0]) sbQ.push_back(commit_entry_t'{pc: p0, ebreak: eb[0], mmio: mm[0]});
        if (mask[1]) sbQ.push_back(commit_entry_t'{pc: p1, ebreak: eb[1], mmio: mm[1]});
    endtask

    // Reset leaves rst_n released just after a rising edge, so the next edge
    // is the first one the design sees in RUN.
    task automatic doReset();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b0;
        sbQ.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drainWait(input int maxCycles);
        int n = 0;
        while (sbQ.size() != 0 && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("drain_empty", 64'(sbQ.size()), 64'd0);
        tick();
        checkOutput("drain_out_valid", out_valid, 1'b0);
    endtask

    // Consumer-side scoreboard: sample on the falling edge; a handshake seen
    // here pops at the following rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pop: got pc 0x%0h expected no entry", out_pc);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("pop_pc", out_pc, monExp.pc);
                checkOutput("pop_ebreak", out_ebreak, monExp.ebreak);
                checkOutput("pop_mmio", out_mmio, monExp.mmio);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{valid: 2'b11, eb: 2'b00, mm: 2'b00, pc0: 32'h80000000, pc1: 32'h80000004, expMask: 2'b11, expStall: 1'b0, expInstret: 64'd2};
        vecs[1] = '{valid: 2'b01, eb: 2'b00, mm: 2'b01, pc0: 32'h80000008, pc1: 32'h0,        expMask: 2'b01, expStall: 1'b0, expInstret: 64'd3};
        vecs[2] = '{valid: 2'b00, eb: 2'b00, mm: 2'b00, pc0: 32'h0,        pc1: 32'h0,        expMask: 2'b00, expStall: 1'b0, expInstret: 64'd3};
        vecs[3] = '{valid: 2'b11, eb: 2'b00, mm: 2'b10, pc0: 32'h8000000C, pc1: 32'h80000010, expMask: 2'b11, expStall: 1'b0, expInstret: 64'd5};
        vecs[4] = '{valid: 2'b01, eb: 2'b00, mm: 2'b00, pc0: 32'h80000014, pc1: 32'h0,        expMask: 2'b01, expStall: 1'b0, expInstret: 64'd6};
        vecs[5] = '{valid: 2'b11, eb: 2'b00, mm: 2'b11, pc0: 32'h80000018, pc1: 32'h8000001C, expMask: 2'b11, expStall: 1'b0, expInstret: 64'd8};

        // Reset values while reset is held.
        tick();
        checkOutput("rst_stall", cmt_stall, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_ebreak", out_ebreak, 1'b0);
        checkOutput("rst_out_mmio", out_mmio, 1'b0);
        checkOutput("rst_instret", instret, 64'd0);
        checkOutput("rst_cycles", cycles, 64'd0);
        checkOutput("rst_finished", finished, 1'b0);
        checkOutput("rst_hang", hang, 1'b0);

        // Table-driven in-order commits with a ready consumer.
        $display("[TB] table vectors");
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].pc0, vecs[i].pc1, vecs[i].eb, vecs[i].mm, 1'b1);
            checkOutput("vec_stall", cmt_stall, vecs[i].expStall);
            expectEnq(vecs[i].expMask, vecs[i].pc0, vecs[i].pc1, vecs[i].eb, vecs[i].mm);
            tick();
            checkOutput("vec_instret", instret, vecs[i].expInstret);
            checkOutput("vec_cycles", cycles, 64'(i + 1));
        end
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
        drainWait(20);

        // Back-pressure: fill to 8, then a fifth group is held until two pops.
        $display("[TB] back-pressure");
        doReset();
        for (int g = 0; g < 4; g++) begin
            applyStimulus(2'b11, 32'h80000100 + 32'(8 * g), 32'h80000104 + 32'(8 * g), 2'b00, 2'b00, 1'b0);
            checkOutput("bp_fill_stall", cmt_stall, 1'b0);
            expectEnq(2'b11, 32'h80000100 + 32'(8 * g), 32'h80000104 + 32'(8 * g), 2'b00, 2'b00);
            tick();
        end
        checkOutput("bp_full_stall", cmt_stall, 1'b1);
        checkOutput("bp_full_valid", out_valid, 1'b1);
        checkOutput("bp_full_instret", instret, 64'd8);
        applyStimulus(2'b11, 32'h80000200, 32'h80000204, 2'b00, 2'b01, 1'b0);
        for (int c = 0; c < 2; c++) begin
            checkOutput("bp_hold_stall", cmt_stall, 1'b1);
            tick();
            checkOutput("bp_hold_instret", instret, 64'd8);
        end
        out_ready = 1'b1;
        checkOutput("bp_pop1_stall", cmt_stall, 1'b1);
        tick();
        checkOutput("bp_pop2_stall", cmt_stall, 1'b1);
        tick();
        checkOutput("bp_free_stall", cmt_stall, 1'b0);
        expectEnq(2'b11, 32'h80000200, 32'h80000204, 2'b00, 2'b01);
        tick();
        checkOutput("bp_accept_instret", instret, 64'd10);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
        drainWait(30);

        // Ebreak on channel 0 trims channel 1, drains, then halts.
        $display("[TB] ebreak");
        doReset();
        applyStimulus(2'b11, 32'h80001000, 32'h80001004, 2'b01, 2'b00, 1'b1);
        checkOutput("eb_stall", cmt_stall, 1'b0);
        expectEnq(2'b01, 32'h80001000, 32'h80001004, 2'b01, 2'b00);
        tick();
        checkOutput("eb_instret", instret, 64'd1);
        checkOutput("eb_finished_early", finished, 1'b0);
        checkOutput("eb_out_valid", out_valid, 1'b1);
        applyStimulus(2'b11, 32'h80001008, 32'h8000100C, 2'b00, 2'b00, 1'b1);
        tick();
        checkOutput("eb_finished", finished, 1'b1);
        checkOutput("eb_cycles_halt", cycles, 64'd2);
        for (int c = 0; c < 4; c++) tick();
        checkOutput("eb_ignored_instret", instret, 64'd1);
        checkOutput("eb_ignored_valid", out_valid, 1'b0);
        checkOutput("eb_finished_sticky", finished, 1'b1);
        checkOutput("eb_cycles_frozen", cycles, 64'd2);
        checkOutput("eb_sb_empty", 64'(sbQ.size()), 64'd0);

        // Idle watchdog with entries left in the queue.
        $display("[TB] watchdog");
        doReset();
        applyStimulus(2'b11, 32'h80002000, 32'h80002004, 2'b00, 2'b10, 1'b0);
        expectEnq(2'b11, 32'h80002000, 32'h80002004, 2'b00, 2'b10);
        tick();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        for (int c = 0; c < 15; c++) tick();
        checkOutput("wd_hang_before", hang, 1'b0);
        tick();
`ifdef COMMIT_WDOG_EN
        checkOutput("wd_hang_set", hang, 1'b1);
`else
        checkOutput("wd_hang_tied", hang, 1'b0);
`endif
        for (int c = 0; c < 3; c++) tick();
`ifdef COMMIT_WDOG_EN
        checkOutput("wd_hang_sticky", hang, 1'b1);
`else
        checkOutput("wd_hang_still0", hang, 1'b0);
`endif
        checkOutput("wd_instret", instret, 64'd2);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
        drainWait(20);
`ifdef COMMIT_WDOG_EN
        applyStimulus(2'b11, 32'h80002100, 32'h80002104, 2'b00, 2'b00, 1'b1);
        tick();
        tick();
        checkOutput("wd_hang_ignores", instret, 64'd2);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
`endif

        // Reset pulse with five entries pending.
        $display("[TB] mid-run reset");
        doReset();
        applyStimulus(2'b11, 32'h80003000, 32'h80003004, 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(2'b11, 32'h80003008, 32'h8000300C, 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(2'b01, 32'h80003010, 32'h0, 2'b00, 2'b00, 1'b0);
        tick();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        checkOutput("mr_pre_instret", instret, 64'd5);
        checkOutput("mr_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("mr_async_valid", out_valid, 1'b0);
        checkOutput("mr_async_instret", instret, 64'd0);
        tick();
        rst_n = 1'b1;
        checkOutput("mr_cycles", cycles, 64'd0);
        checkOutput("mr_out_pc", out_pc, 32'h0);
        checkOutput("mr_stall", cmt_stall, 1'b0);
        applyStimulus(2'b01, 32'h80003100, 32'h0, 2'b00, 2'b01, 1'b1);
        expectEnq(2'b01, 32'h80003100, 32'h0, 2'b00, 2'b01);
        tick();
        checkOutput("mr_post_instret", instret, 64'd1);
        checkOutput("mr_post_valid", out_valid, 1'b1);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
        drainWait(10);

        // Twenty single commits across pointer wrap with continuous pop.
        $display("[TB] wrap-around");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2'b01, 32'h80004000 + 32'(4 * i), 32'h0, 2'b00, {1'b0, 1'(i)}, 1'b1);
            checkOutput("wrap_stall", cmt_stall, 1'b0);
            expectEnq(2'b01, 32'h80004000 + 32'(4 * i), 32'h0, 2'b00, {1'b0, 1'(i)});
            tick();
        end
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
        drainWait(10);
        checkOutput("wrap_instret", instret, 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
